// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss/hit sequencer:
// FSM states, control-word layout and default geometry.
package cache_pkg;

    localparam int DEF_TAG_WIDTH    = 18;
    localparam int DEF_SET_WIDTH    = 10;
    localparam int DEF_OFFSET_WIDTH = 4;
    localparam int WORDS            = 2 ** (DEF_OFFSET_WIDTH - 2);

    typedef enum logic [1:0] {
        COMPARE    = 2'd0,
        WRITE_BACK = 2'd1,
        ALLOCATE   = 2'd2
    } state_t;

    localparam int CTRL_OFFSET_SEL  = 0;
    localparam int CTRL_STRATEGY_EN = 1;
    localparam int CTRL_SET_DIRTY   = 2;
    localparam int CTRL_SET_VALID   = 3;
    localparam int CTRL_WRITE_EN    = 4;

    typedef struct packed {
        logic write_en;
        logic set_valid;
        logic set_dirty;
        logic strategy_en;
        logic offset_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE      = '0;
    localparam ctrl_t CTRL_READ_HIT  = ctrl_t'((5'd1 << CTRL_STRATEGY_EN) | (5'd1 << CTRL_OFFSET_SEL));
    localparam ctrl_t CTRL_WRITE_HIT = ctrl_t'(CTRL_READ_HIT | (5'd1 << CTRL_SET_DIRTY)
                                             | (5'd1 << CTRL_SET_VALID) | (5'd1 << CTRL_WRITE_EN));

endpackage

// File: rtl/line_beat_counter.sv
// Word-within-line counter used while streaming a line to or from memory.
// Wraps naturally after the last word, so no separate clear is needed on the final beat.
module line_beat_counter #(
    parameter int BEAT_WIDTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    output logic [BEAT_WIDTH-1:0] beat_o,
    output logic                  last_o
);

    logic [BEAT_WIDTH-1:0] beat_q, beat_d;

    always_comb begin
        beat_d = beat_q;
        if (clr_i) begin
            beat_d = '0;
        end else if (en_i) begin
            beat_d = beat_q + BEAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign beat_o = beat_q;
    assign last_o = &beat_q;

endmodule

// File: rtl/cache_fsm.sv
// Miss/hit sequencer for one cache: services hits in the request cycle, otherwise
// writes back a dirty victim, refills the line word by word and re-looks it up.
module cache_fsm
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH    = DEF_TAG_WIDTH,
    parameter int SET_WIDTH    = DEF_SET_WIDTH,
    parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 read_i,
    input  logic                 write_i,
    input  logic [31:0]          addr_i,
    input  logic                 hit_i,
    input  logic                 dirty_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    input  logic                 mem_ready_i,
    output logic [4:0]           control_o,
    output logic                 ready_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o
);

    localparam int BEAT_WIDTH = OFFSET_WIDTH - 2;

    state_t                 state_q, state_d;
    logic [TAG_WIDTH-1:0]   victim_tag_q, victim_tag_d;
    logic [BEAT_WIDTH-1:0]  beat;
    logic                   beat_last;
    logic                   beat_en;
    logic                   beat_clr;
    ctrl_t                  ctrl;

    logic [SET_WIDTH-1:0]   index;
    logic [TAG_WIDTH-1:0]   addr_tag;
    logic                   unused_addr_bits;

    assign index            = addr_i[OFFSET_WIDTH+SET_WIDTH-1:OFFSET_WIDTH];
    assign addr_tag         = addr_i[31:32-TAG_WIDTH];
    assign unused_addr_bits = ^addr_i[OFFSET_WIDTH-1:0];

    line_beat_counter #(
        .BEAT_WIDTH(BEAT_WIDTH)
    ) u_beat (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (beat_en),
        .clr_i (beat_clr),
        .beat_o(beat),
        .last_o(beat_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= COMPARE;
            victim_tag_q <= '0;
        end else begin
            state_q      <= state_d;
            victim_tag_q <= victim_tag_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        victim_tag_d = victim_tag_q;
        ctrl         = CTRL_IDLE;
        ready_o      = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        beat_en      = 1'b0;
        beat_clr     = 1'b0;

        unique case (state_q)
            COMPARE: begin
                ready_o  = 1'b1;
                beat_clr = 1'b1;
                if (read_i || write_i) begin
                    if (hit_i) begin
                        // A simultaneous read and write is serviced as a write.
                        ctrl = write_i ? CTRL_WRITE_HIT : CTRL_READ_HIT;
                    end else begin
                        ready_o      = 1'b0;
                        victim_tag_d = tag_i;
                        state_d      = dirty_i ? WRITE_BACK : ALLOCATE;
                    end
                end
            end
            WRITE_BACK: begin
                mem_write_o = 1'b1;
                mem_addr_o  = {victim_tag_q, index, beat, 2'b00};
                if (mem_ready_i) begin
                    beat_en = 1'b1;
                    if (beat_last) begin
                        state_d = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                mem_read_o = 1'b1;
                mem_addr_o = {addr_tag, index, beat, 2'b00};
                if (mem_ready_i) begin
                    beat_en = 1'b1;
                    // Line stays invalid until its last word lands, so a partial fill never hits.
                    ctrl[CTRL_WRITE_EN]  = 1'b1;
                    ctrl[CTRL_SET_VALID] = beat_last;
                    if (beat_last) begin
                        state_d = COMPARE;
                    end
                end
            end
            default: begin
                state_d = COMPARE;
            end
        endcase

        if (rst_i) begin
            ctrl        = CTRL_IDLE;
            ready_o     = 1'b1;
            mem_read_o  = 1'b0;
            mem_write_o = 1'b0;
            mem_addr_o  = '0;
        end
    end

    assign control_o = ctrl;

endmodule

// File: tb/tb_cache_fsm.sv
// Bench for cache_fsm: a behavioural set array answers lookups, and a scoreboard
// of expected memory handshakes is checked as the sequencer produces them.
module tb_cache_fsm;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        read_i = 1'b0;
    logic        write_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        hit_i;
    logic        dirty_i;
    logic [17:0] tag_i;
    logic        mem_ready_i = 1'b1;
    logic [4:0]  control_o;
    logic        ready_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o;

    cache_fsm dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .read_i     (read_i),
        .write_i    (write_i),
        .addr_i     (addr_i),
        .hit_i      (hit_i),
        .dirty_i    (dirty_i),
        .tag_i      (tag_i),
        .mem_ready_i(mem_ready_i),
        .control_o  (control_o),
        .ready_o    (ready_o),
        .mem_read_o (mem_read_o),
        .mem_write_o(mem_write_o),
        .mem_addr_o (mem_addr_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int hs_count = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Set array model: one way, indexed by addr[13:4], tag addr[31:14].
    bit          vld [1024];
    bit          dty [1024];
    logic [17:0] tgm [1024];
    logic [9:0]  cur_idx;
    logic [17:0] cur_tag;

    assign cur_idx = addr_i[13:4];
    assign cur_tag = addr_i[31:14];
    assign hit_i   = vld[cur_idx] && (tgm[cur_idx] == cur_tag);
    assign dirty_i = vld[cur_idx] && dty[cur_idx];
    assign tag_i   = tgm[cur_idx];

    always @(posedge clk) begin
        if (!rst_i && control_o[4]) begin
            vld[cur_idx] <= control_o[3];
            dty[cur_idx] <= control_o[2];
            if (control_o[3]) tgm[cur_idx] <= cur_tag;
        end
    end

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [4:0]  ctrl;
    } txn_t;

    txn_t sb_q[$];

    function automatic void push_expect(input logic [31:0] a);
        logic [9:0]  ix = a[13:4];
        logic [17:0] tg = a[31:14];
        logic [1:0]  bb;
        txn_t        t;
        if (vld[ix] && tgm[ix] == tg) return;
        if (vld[ix] && dty[ix]) begin
            for (int b = 0; b < WORDS; b++) begin
                bb = 2'(b);
                t.wr = 1'b1; t.addr = {tgm[ix], ix, bb, 2'b00}; t.ctrl = 5'b00000;
                sb_q.push_back(t);
            end
        end
        for (int b = 0; b < WORDS; b++) begin
            bb = 2'(b);
            t.wr = 1'b0; t.addr = {tg, ix, bb, 2'b00};
            t.ctrl = (b == WORDS - 1) ? 5'b11000 : 5'b10000;
            sb_q.push_back(t);
        end
    endfunction

    always @(negedge clk) begin : monitor
        txn_t t;
        if (!rst_i && (mem_read_o || mem_write_o) && mem_ready_i) begin
            hs_count++;
            $display("hs %s addr=0x%08h ctrl=%05b", mem_write_o ? "WR" : "RD", mem_addr_o, control_o);
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_hs", 32'd1, 32'd0);
            end else begin
                t = sb_q.pop_front();
                check_val("hs_is_write", 32'(mem_write_o), 32'(t.wr));
                check_val("hs_addr", mem_addr_o, t.addr);
                check_val("hs_ctrl", 32'(control_o), 32'(t.ctrl));
            end
        end
    end

    task automatic wait_ready(output int low_cycles);
        low_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready_o) break;
            low_cycles++;
        end
        if (!ready_o) check_val("ready_timeout", 32'(ready_o), 32'd1);
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          output int low_cycles, output logic [4:0] ctrl_rdy, output logic strobe_rdy);
        @(posedge clk); #1;
        read_i = rd; write_i = wr; addr_i = a;
        push_expect(a);
        wait_ready(low_cycles);
        ctrl_rdy   = control_o;
        strobe_rdy = mem_read_o | mem_write_o;
        $display("req rd=%0b wr=%0b addr=0x%08h low=%0d ctrl=%05b", rd, wr, a, low_cycles, ctrl_rdy);
        @(posedge clk); #1;
        read_i = 1'b0; write_i = 1'b0;
        check_val("sb_drained", sb_q.size(), 32'd0);
    endtask

    initial begin : stim
        int         low;
        int         hs0;
        int         stable;
        logic [4:0] c;
        logic       s;
        bit         found;

        for (int i = 0; i < 1024; i++) begin
            vld[i] = 1'b0; dty[i] = 1'b0; tgm[i] = '0;
        end

        #2;
        check_val("rst_ready", 32'(ready_o), 32'd1);
        check_val("rst_ctrl", 32'(control_o), 32'd0);
        check_val("rst_mem_read", 32'(mem_read_o), 32'd0);
        check_val("rst_mem_write", 32'(mem_write_o), 32'd0);
        check_val("rst_mem_addr", mem_addr_o, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check_val("idle_ready", 32'(ready_o), 32'd1);
        check_val("idle_ctrl", 32'(control_o), 32'd0);

        // T1: reset while the fill is offering beat 2
        @(posedge clk); #1;
        read_i = 1'b1; addr_i = 32'h1000;
        push_expect(32'h1000);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_read_o && mem_addr_o == 32'h1008) begin
                found = 1'b1;
                break;
            end
        end
        check_val("t1_reached_beat2", 32'(found), 32'd1);
        #1 rst_i = 1'b1;
        #1;
        check_val("t1_rst_mem_read", 32'(mem_read_o), 32'd0);
        check_val("t1_rst_mem_write", 32'(mem_write_o), 32'd0);
        check_val("t1_rst_mem_addr", mem_addr_o, 32'd0);
        check_val("t1_rst_ctrl", 32'(control_o), 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0; read_i = 1'b0;
        sb_q.delete();

        // T1/T2: re-read 0x1000 must miss and refill from beat 0
        do_req(1'b1, 1'b0, 32'h1000, low, c, s);
        check_val("t2_miss_latency", low, 32'd5);
        check_val("t2_ready_ctrl", 32'(c), 32'b00011);
        check_val("t2_ready_no_strobe", 32'(s), 32'd0);

        // T3: write hit
        do_req(1'b0, 1'b1, 32'h1004, low, c, s);
        check_val("t3_latency", low, 32'd0);
        check_val("t3_ctrl", 32'(c), 32'b11111);
        check_val("t3_no_strobe", 32'(s), 32'd0);

        // T4: make index 0 dirty with tag 0xAB, then miss on tag 0xCD
        do_req(1'b0, 1'b1, 32'h002A_C000, low, c, s);
        check_val("t4_setup_latency", low, 32'd5);
        check_val("t4_setup_ctrl", 32'(c), 32'b11111);
        hs0 = hs_count;
        do_req(1'b1, 1'b0, 32'h0033_4000, low, c, s);
        check_val("t4_handshakes", hs_count - hs0, 32'd8);
        // One lookup cycle plus one cycle per handshake, no idle gaps.
        check_val("t4_ready_low", low, 32'd9);
        check_val("t4_ready_ctrl", 32'(c), 32'b00011);

        // T5: stall the write-back, then a single-cycle ready pulse
        do_req(1'b0, 1'b1, 32'h0033_4000, low, c, s);
        check_val("t5_setup_ctrl", 32'(c), 32'b11111);
        @(posedge clk); #1;
        mem_ready_i = 1'b0;
        read_i = 1'b1; addr_i = 32'h002A_C000;
        push_expect(32'h002A_C000);
        @(negedge clk);
        stable = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_write_o && mem_addr_o == 32'h0033_4000) stable++;
        end
        check_val("t5_stall_stable", stable, 32'd5);
        @(posedge clk); #1 mem_ready_i = 1'b1;
        @(posedge clk); #1 mem_ready_i = 1'b0;
        @(negedge clk);
        check_val("t5_pulse_addr", mem_addr_o, 32'h0033_4004);
        check_val("t5_pulse_strobe", 32'(mem_write_o), 32'd1);
        @(posedge clk); #1 mem_ready_i = 1'b1;
        wait_ready(low);
        check_val("t5_ready_ctrl", 32'(control_o), 32'b00011);
        @(posedge clk); #1 read_i = 1'b0;
        check_val("t5_sb_drained", sb_q.size(), 32'd0);

        // T6: read and write together on a hit
        do_req(1'b1, 1'b1, 32'h002A_C000, low, c, s);
        check_val("t6_latency", low, 32'd0);
        check_val("t6_ctrl", 32'(c), 32'b11111);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
